spi_slave_shifter: RTL and testbench



---
 rtl/mini_spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 53 +++++
 rtl/spi_slave_shifter.sv | 145 ++++++++++++++
 tb/tb_spi_slave_shifter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mini_spi_pkg.sv
// Shared definitions for the Mini_SPI slave path: default sizes, the
// frame-state encoding and the bit-counter width helper.
package mini_spi_pkg;

  localparam int unsigned DEF_N           = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Width of a counter that walks 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin plus registered
// rise/fall strobes. Strobes stay quiet until the chain and the edge
// register hold genuine pin samples, so a pin already sitting at the
// non-idle level when reset releases does not look like a fresh edge.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_q, vld_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Next-state: shift the pin in, remember the last synchronised level, detect edges.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
    vld_d  = {vld_q[STAGES-1:0], 1'b1};
    rise_d = vld_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    fall_d = vld_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;
  end

  // Register update; the chain resets to the pin's idle level.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would let later statements see already-updated flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// Mode-0 SPI slave byte engine. SCK, CS_n and MOSI are oversampled in the
// clk domain; MOSI is shifted in on SCK rise (MSB first), MISO is shifted
// out on SCK fall, and tx_data is reloaded at every word boundary so words
// can stream back-to-back inside one chip-select frame.
module spi_slave_shifter
  import mini_spi_pkg::*;
#(
  parameter int unsigned N           = DEF_N,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spi_sck,
  input  logic         spi_cs_n,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic         spi_miso_oe,
  input  logic [N-1:0] tx_data,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         busy,
  output logic         frame_err
);

  localparam int unsigned CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_sync;

  spi_state_e state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]     rx_shift_q, rx_shift_d;
  logic [N-1:0]     tx_shift_q, tx_shift_d;
  logic [N-1:0]     rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             miso_q, miso_d;

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  // Frame FSM and shift datapath; CS rise takes priority over any SCK strobe.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_data;
          miso_d     = tx_data[N-1];
          bit_cnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
        end else if (sck_rise) begin
          rx_shift_d = (rx_shift_q << 1) | {{(N-1){1'b0}}, mosi_sync};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == '0) begin
            tx_shift_d = tx_data;
            miso_d     = tx_data[N-1];
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_d[N-1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a table of single-byte frames with
// fixed tx_data, then hand-written sequences for reset mid-frame, SCK
// activity outside a frame, aborted frames and two's-complement loopback.
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  logic       loop_mode = 1'b0;
  logic [7:0] tx_fixed = 8'h00;

  int total = 0;
  int bad   = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;

  assign tx_data = loop_mode ? (~rx_data + 8'd1) : tx_fixed;

  spi_slave_shifter #(.N(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid)    rv_cnt++;
    if (frame_err)   fe_cnt++;
    if (spi_miso_oe) oe_cnt++;
  end

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SCK period at clk/8: MOSI set during low phase, MISO sampled at the rise.
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
    logic bit_m;
    m = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], bit_m);
      m = {m[6:0], bit_m};
    end
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] prev;
    logic [7:0] b;
    logic       dummy;
    int rv0, fe0, oe0;

    vecs[0] = '{mosi: 8'h3C, tx: 8'hA5, exp_miso: 8'hA5, exp_rx: 8'h3C};
    vecs[1] = '{mosi: 8'hFF, tx: 8'h00, exp_miso: 8'h00, exp_rx: 8'hFF};
    vecs[2] = '{mosi: 8'h00, tx: 8'hFF, exp_miso: 8'hFF, exp_rx: 8'h00};
    vecs[3] = '{mosi: 8'h81, tx: 8'h7E, exp_miso: 8'h7E, exp_rx: 8'h81};
    vecs[4] = '{mosi: 8'h5A, tx: 8'hC3, exp_miso: 8'hC3, exp_rx: 8'h5A};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    check("reset_miso", spi_miso, 0);
    check("reset_oe", spi_miso_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid_cnt", rv_cnt, 0);
    check("reset_frame_err_cnt", fe_cnt, 0);

    // Table: one byte per frame with a fixed transmit word.
    loop_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_fixed = vecs[i].tx;
      rv0 = rv_cnt;
      fe0 = fe_cnt;
      cs_start();
      check($sformatf("vec%0d_busy", i), busy, 1);
      check($sformatf("vec%0d_oe", i), spi_miso_oe, 1);
      spi_byte(vecs[i].mosi, got);
      cs_end();
      check($sformatf("vec%0d_miso", i), got, vecs[i].exp_miso);
      check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      check($sformatf("vec%0d_rx_valid_cnt", i), rv_cnt - rv0, 1);
      check($sformatf("vec%0d_frame_err_cnt", i), fe_cnt - fe0, 0);
      check($sformatf("vec%0d_idle_busy", i), busy, 0);
    end

    // Reset mid-frame with CS held low: no frame until a fresh CS fall.
    tx_fixed = 8'hA5;
    cs_start();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, dummy);
    do_reset();
    check("midrst_miso", spi_miso, 0);
    check("midrst_oe", spi_miso_oe, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    spi_byte(8'hC6, got);
    check("midrst_lowcs_rx_valid_cnt", rv_cnt - rv0, 0);
    check("midrst_lowcs_busy", busy, 0);
    cs_end();
    cs_start();
    spi_byte(8'h96, got);
    cs_end();
    check("midrst_new_miso", got, 8'hA5);
    check("midrst_new_rx_data", rx_data, 8'h96);
    check("midrst_new_rx_valid_cnt", rv_cnt - rv0, 1);
    check("midrst_new_frame_err_cnt", fe_cnt - fe0, 0);

    // SCK toggling with CS high: 16 edges, nothing may happen.
    rv0 = rv_cnt;
    oe0 = oe_cnt;
    for (int i = 0; i < 8; i++) spi_bit(i[0], dummy);
    repeat (6) @(negedge clk);
    check("idle_sck_rx_valid_cnt", rv_cnt - rv0, 0);
    check("idle_sck_oe_cnt", oe_cnt - oe0, 0);
    check("idle_sck_bit_cnt", 32'(dut.bit_cnt_q), 0);
    check("idle_sck_busy", busy, 0);

    // Abort after 5 SCK cycles: one frame_err, rx_data keeps 8'h96.
    tx_fixed = 8'h11;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    cs_start();
    for (int i = 0; i < 5; i++) spi_bit(1'b0, dummy);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_busy_latency", busy, 0);
    repeat (6) @(negedge clk);
    check("abort_frame_err_cnt", fe_cnt - fe0, 1);
    check("abort_rx_data", rx_data, 8'h96);
    check("abort_rx_valid_cnt", rv_cnt - rv0, 0);
    check("abort_bit_cnt", 32'(dut.bit_cnt_q), 0);

    // Loopback, three bytes in one frame starting from reset rx_data = 0.
    do_reset();
    repeat (6) @(negedge clk);
    loop_mode = 1'b1;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    cs_start();
    spi_byte(8'h01, got);
    check("loop3_miso0", got, 8'h00);
    spi_byte(8'h05, got);
    check("loop3_miso1", got, 8'hFF);
    spi_byte(8'h80, got);
    check("loop3_miso2", got, 8'hFB);
    cs_end();
    check("loop3_rx_data", rx_data, 8'h80);
    check("loop3_rx_valid_cnt", rv_cnt - rv0, 3);
    check("loop3_frame_err_cnt", fe_cnt - fe0, 0);

    // Rate edge: SCK = clk/8, 64 random bytes in one loopback frame.
    prev = 8'h80;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    cs_start();
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      spi_byte(b, got);
      check($sformatf("rate_miso%0d", i), got, 8'(~prev + 8'd1));
      prev = b;
    end
    cs_end();
    check("rate_rx_data", rx_data, prev);
    check("rate_rx_valid_cnt", rv_cnt - rv0, 64);
    check("rate_frame_err_cnt", fe_cnt - fe0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
